doodle_jump_engine: RTL and testbench

//  Parametrised successor of the doodle jump/fall state machine. Holds a writable table of NUM_PLATS

---
 rtl/doodle_jump_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_doodle_jump_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doodle_jump_engine.sv
`default_nettype none
// ============================================================================
// Module      : doodle_jump_engine
// Description : Doodle jump/fall state machine with a writable platform table.
//               Landing is resolved by a sequential scan, one entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module doodle_jump_engine #(
  parameter int NUM_PLATS     = 16,
  parameter int IDX_W         = 4,
  parameter int COORD_W       = 16,
  parameter int JUMP_HEIGHT   = 120,
  parameter int DOODLE_RADIUS = 13,
  parameter int PLAT_RADIUS_W = 32,
  parameter int PLAT_RADIUS_H = 7,
  parameter int V_MIDDLE      = 275,
  parameter int SCREEN_BOTTOM = 515
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Ack,
  input  logic               frame_tick,
  input  logic [3:0]         vert_speed,
  input  logic [COORD_W-1:0] doodle_x,
  input  logic [COORD_W-1:0] doodle_y,
  input  logic               plat_we,
  input  logic [IDX_W-1:0]   plat_widx,
  input  logic [COORD_W-1:0] plat_wx,
  input  logic [COORD_W-1:0] plat_wy,
  input  logic               plat_wvalid,
  input  logic [IDX_W-1:0]   plat_ridx,
  output logic [COORD_W-1:0] plat_rx,
  output logic [COORD_W-1:0] plat_ry,
  output logic               plat_rvalid,
  output logic               q_I,
  output logic               q_Up,
  output logic               q_Down,
  output logic               q_Done,
  output logic               is_in_middle,
  output logic [COORD_W-1:0] v_counter,
  output logic [COORD_W-1:0] score,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               tick_overrun
);

  localparam logic [COORD_W-1:0] c_dr       = COORD_W'(DOODLE_RADIUS);
  localparam logic [COORD_W-1:0] c_pw       = COORD_W'(PLAT_RADIUS_W);
  localparam logic [COORD_W-1:0] c_ph       = COORD_W'(PLAT_RADIUS_H);
  localparam logic [COORD_W-1:0] c_jump     = COORD_W'(JUMP_HEIGHT);
  localparam logic [COORD_W-1:0] c_v_middle = COORD_W'(V_MIDDLE);
  localparam logic [COORD_W-1:0] c_bottom   = COORD_W'(SCREEN_BOTTOM);
  localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(NUM_PLATS - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_UP   = 4'b0010,
    S_DOWN = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   up_count_q, up_count_d;
  logic [COORD_W-1:0]   v_counter_q, v_counter_d;
  logic [COORD_W-1:0]   score_q, score_d;
  logic                 is_in_middle_q, is_in_middle_d;
  logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
  logic                 tick_overrun_q, tick_overrun_d;
  logic                 scanning_q, scanning_d;
  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic [COORD_W-1:0]   plat_x_q [NUM_PLATS];
  logic [COORD_W-1:0]   plat_x_d [NUM_PLATS];
  logic [COORD_W-1:0]   plat_y_q [NUM_PLATS];
  logic [COORD_W-1:0]   plat_y_d [NUM_PLATS];
  logic [NUM_PLATS-1:0] plat_v_q, plat_v_d;

  logic [COORD_W:0]     up_sum, score_sum;
  logic [COORD_W-1:0]   up_sat, score_sat;
  logic [COORD_W-1:0]   scan_px, scan_py;
  logic [COORD_W-1:0]   doodle_right, doodle_left, plat_left, plat_right;
  logic [COORD_W-1:0]   doodle_feet, plat_top, plat_bot;
  logic                 hit;

  assign up_sum    = {1'b0, up_count_q} + (COORD_W+1)'(vert_speed);
  assign up_sat    = up_sum[COORD_W] ? '1 : up_sum[COORD_W-1:0];
  assign score_sum = {1'b0, score_q} + (COORD_W+1)'(vert_speed);
  assign score_sat = score_sum[COORD_W] ? '1 : score_sum[COORD_W-1:0];

  // Platform y lives in world coordinates; adding the scroll maps it to screen y.
  assign scan_px      = plat_x_q[scan_idx_q];
  assign scan_py      = plat_y_q[scan_idx_q];
  assign doodle_right = doodle_x + c_dr;
  assign doodle_left  = doodle_x - c_dr;
  assign plat_left    = scan_px - c_pw;
  assign plat_right   = scan_px + c_pw;
  assign doodle_feet  = doodle_y + c_dr;
  assign plat_top     = scan_py + v_counter_q - c_ph;
  assign plat_bot     = scan_py + v_counter_q + c_ph;
  assign hit = plat_v_q[scan_idx_q] && (doodle_right >= plat_left) && (doodle_left <= plat_right)
               && (doodle_feet >= plat_top) && (doodle_feet <= plat_bot);

  always_comb begin
    state_d        = state_q;
    up_count_d     = up_count_q;
    v_counter_d    = v_counter_q;
    score_d        = score_q;
    is_in_middle_d = is_in_middle_q;
    hit_idx_d      = hit_idx_q;
    tick_overrun_d = tick_overrun_q;
    scanning_d     = scanning_q;
    scan_idx_d     = scan_idx_q;
    plat_x_d       = plat_x_q;
    plat_y_d       = plat_y_q;
    plat_v_d       = plat_v_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d    = S_UP;
          up_count_d = '0;
        end
      end
      S_UP: begin
        if (frame_tick) begin
          up_count_d = up_sat;
          if (doodle_y <= c_v_middle) begin
            v_counter_d    = v_counter_q + COORD_W'(vert_speed);
            score_d        = score_sat;
            is_in_middle_d = 1'b1;
          end else begin
            is_in_middle_d = 1'b0;
          end
          if (up_sat >= c_jump) state_d = S_DOWN;
        end
      end
      S_DOWN: begin
        if (scanning_q) begin
          if (frame_tick) tick_overrun_d = 1'b1;
          if (hit) begin
            hit_idx_d  = scan_idx_q;
            up_count_d = '0;
            state_d    = S_UP;
            scanning_d = 1'b0;
            scan_idx_d = '0;
          end else if (scan_idx_q == c_last_idx) begin
            scanning_d = 1'b0;
            scan_idx_d = '0;
          end else begin
            scan_idx_d = scan_idx_q + 1'b1;
          end
        end else if (frame_tick) begin
          if (doodle_y > c_bottom) begin
            state_d = S_DONE;
          end else begin
            scanning_d = 1'b1;
            scan_idx_d = '0;
          end
        end
      end
      S_DONE: begin
        if (Ack) begin
          state_d        = S_IDLE;
          v_counter_d    = '0;
          score_d        = '0;
          is_in_middle_d = 1'b0;
          tick_overrun_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        scanning_d = 1'b0;
        scan_idx_d = '0;
      end
    endcase

    // The scan reads the registered table, so a same-cycle write is seen only by later scans.
    if (plat_we) begin
      plat_x_d[plat_widx] = plat_wx;
      plat_y_d[plat_widx] = plat_wy;
      plat_v_d[plat_widx] = plat_wvalid;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= S_IDLE;
      up_count_q     <= '0;
      v_counter_q    <= '0;
      score_q        <= '0;
      is_in_middle_q <= 1'b0;
      hit_idx_q      <= '0;
      tick_overrun_q <= 1'b0;
      scanning_q     <= 1'b0;
      scan_idx_q     <= '0;
      plat_v_q       <= '0;
    end else begin
      state_q        <= state_d;
      up_count_q     <= up_count_d;
      v_counter_q    <= v_counter_d;
      score_q        <= score_d;
      is_in_middle_q <= is_in_middle_d;
      hit_idx_q      <= hit_idx_d;
      tick_overrun_q <= tick_overrun_d;
      scanning_q     <= scanning_d;
      scan_idx_q     <= scan_idx_d;
      plat_v_q       <= plat_v_d;
    end
  end

  // Coordinates are only meaningful alongside a set valid bit, so they carry no reset.
  always_ff @(posedge Clk) begin
    plat_x_q <= plat_x_d;
    plat_y_q <= plat_y_d;
  end

  assign plat_rx      = plat_x_q[plat_ridx];
  assign plat_ry      = plat_y_q[plat_ridx];
  assign plat_rvalid  = plat_v_q[plat_ridx];
  assign q_I          = (state_q == S_IDLE);
  assign q_Up         = (state_q == S_UP);
  assign q_Down       = (state_q == S_DOWN);
  assign q_Done       = (state_q == S_DONE);
  assign is_in_middle = is_in_middle_q;
  assign v_counter    = v_counter_q;
  assign score        = score_q;
  assign hit_idx      = hit_idx_q;
  assign tick_overrun = tick_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_doodle_jump_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_doodle_jump_engine
// Description : Self-checking bench: directed scenarios plus random stimulus
//               against a frame-level reference model of the doodle engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_doodle_jump_engine;
  localparam int NP = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, ack, tick, we, wvalid;
  logic [3:0]  spd, widx, ridx;
  logic [15:0] dx, dy, wx, wy;
  logic [15:0] rx, ry, vcnt, scr;
  logic        rvalid, qi, qup, qdown, qdone, mid, ovr;
  logic [3:0]  hidx;

  always #5 clk = ~clk;

  doodle_jump_engine dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Ack(ack), .frame_tick(tick),
    .vert_speed(spd), .doodle_x(dx), .doodle_y(dy), .plat_we(we), .plat_widx(widx),
    .plat_wx(wx), .plat_wy(wy), .plat_wvalid(wvalid), .plat_ridx(ridx),
    .plat_rx(rx), .plat_ry(ry), .plat_rvalid(rvalid), .q_I(qi), .q_Up(qup),
    .q_Down(qdown), .q_Done(qdone), .is_in_middle(mid), .v_counter(vcnt),
    .score(scr), .hit_idx(hidx), .tick_overrun(ovr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 IDLE, 1 UP, 2 DOWN, 3 DONE; a scan is a countdown to a precomputed outcome.
  int          m_st, m_up, m_score, m_hit, m_rem, m_found;
  logic [15:0] m_v;
  bit          m_mid, m_ovr;
  logic [15:0] m_px [NP];
  logic [15:0] m_py [NP];
  bit          m_pv [NP];

  function automatic int first_hit();
    logic [15:0] a, b, c, d, f, t, u;
    for (int i = 0; i < NP; i++) begin
      if (!m_pv[i]) continue;
      a = dx + 16'd13;  b = m_px[i] - 16'd32;
      c = dx - 16'd13;  d = m_px[i] + 16'd32;
      f = dy + 16'd13;
      t = m_py[i] + m_v - 16'd7;
      u = m_py[i] + m_v + 16'd7;
      if (a >= b && c <= d && f >= t && f <= u) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_up = 0; m_v = 16'd0; m_score = 0; m_mid = 0;
    m_hit = 0; m_ovr = 0; m_rem = 0; m_found = -1;
    for (int i = 0; i < NP; i++) m_pv[i] = 0;
  endtask

  task automatic model_step();
    case (m_st)
      0: if (start) begin m_st = 1; m_up = 0; end
      1: if (tick) begin
        m_up = m_up + int'(spd);
        if (m_up > 65535) m_up = 65535;
        if (dy <= 16'd275) begin
          m_v = m_v + 16'(spd);
          m_score = m_score + int'(spd);
          if (m_score > 65535) m_score = 65535;
          m_mid = 1;
        end else m_mid = 0;
        if (m_up >= 120) m_st = 2;
      end
      2: if (m_rem > 0) begin
        if (tick) m_ovr = 1;
        m_rem--;
        if (m_rem == 0 && m_found >= 0) begin m_hit = m_found; m_up = 0; m_st = 1; end
      end else if (tick) begin
        if (dy > 16'd515) m_st = 3;
        else begin
          m_found = first_hit();
          m_rem = (m_found >= 0) ? m_found + 1 : NP;
        end
      end
      default: if (ack) begin m_st = 0; m_v = 16'd0; m_score = 0; m_mid = 0; m_ovr = 0; end
    endcase
    if (we) begin m_px[widx] = wx; m_py[widx] = wy; m_pv[widx] = wvalid; end
  endtask

  task automatic compare_all();
    logic [3:0] es;
    es = 4'b0001 << m_st;
    check("state", {qdone, qdown, qup, qi}, es);
    check("v_counter", vcnt, m_v);
    check("score", scr, m_score);
    check("is_in_middle", mid, m_mid);
    check("hit_idx", hidx, m_hit);
    check("tick_overrun", ovr, m_ovr);
    check("plat_rvalid", rvalid, m_pv[ridx]);
    if (m_pv[ridx]) begin
      check("plat_rx", rx, m_px[ridx]);
      check("plat_ry", ry, m_py[ridx]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_plat(input int i, input logic [15:0] x, input logic [15:0] y, input bit v);
    we = 1'b1; widx = 4'(i); wx = x; wy = y; wvalid = v;
    cyc();
    we = 1'b0;
  endtask

  task automatic up_tick(input int s);
    spd = 4'(s); tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Place platform 0 under the doodle at the current scroll, then tick to land on it.
  task automatic land();
    int g;
    write_plat(0, dx, dy + 16'd13 - m_v, 1'b1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    g = 0;
    while (m_rem > 0 && g < 40) begin cyc(); g++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, s;
    logic [15:0] diff;
    bit quiet, did_mid_reset;
    rst_n = 1'b0; start = 0; ack = 0; tick = 0; we = 0; wvalid = 0;
    spd = 4'd0; widx = 4'd0; ridx = 4'd0; dx = 16'd320; dy = 16'd400; wx = 16'd0; wy = 16'd0;
    model_reset();
    #12;
    compare_all();
    check("reset_idle", qi, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // 30 ticks of 4 pixels below the middle: no scroll, DOWN exactly on tick 30.
    dy = 16'd400; spd = 4'd4; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      up_tick(4);
      if (i == 28) check("t1_up_after_29", qup, 1'b1);
      cyc();
    end
    check("t1_down", qdown, 1'b1);
    check("t1_vcnt", vcnt, 16'd0);

    // Scrolling at speed 5 in the upper half.
    do_reset();
    dy = 16'd200; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) up_tick(5);
    check("t2_vcnt", vcnt, 16'd15);
    check("t2_score", scr, 16'd15);
    check("t2_mid", mid, 1'b1);

    // Two hitting entries: lowest index wins, UP four cycles after the tick.
    dy = 16'd400;
    for (int i = 0; i < 7; i++) up_tick(15);
    check("t3_down", qdown, 1'b1);
    write_plat(3, 16'd320, 16'd398, 1'b1);
    write_plat(9, 16'd330, 16'd400, 1'b1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("t3_up_c%0d", k), qup, (k == 4) ? 1'b1 : 1'b0);
    end
    check("t3_hit_idx", hidx, 4'd3);
    for (int i = 0; i < 7; i++) up_tick(15);
    check("t3_up_count_cleared", qup, 1'b1);
    up_tick(15);
    check("t3_down_again", qdown, 1'b1);

    // Full miss scan with a second tick five cycles in.
    write_plat(3, 16'd320, 16'd398, 1'b0);
    write_plat(9, 16'd330, 16'd400, 1'b0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("t5_overrun", ovr, 1'b1);
    for (int i = 0; i < 11; i++) cyc();
    check("t5_still_down", qdown, 1'b1);

    // Falling off the bottom, then Ack.
    dy = 16'd516; tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("t4_done", qdone, 1'b1);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    check("t4_idle", qi, 1'b1);
    check("t4_vcnt", vcnt, 16'd0);
    check("t4_score", scr, 16'd0);
    check("t4_overrun_clr", ovr, 1'b0);
    ridx = 4'd3;
    #1;
    check("t4_table_ry", ry, 16'd398);
    check("t4_table_rx", rx, 16'd320);

    // Long climb to the wrap point of v_counter and saturation of score.
    do_reset();
    dx = 16'd320; dy = 16'd200; start = 1'b1;
    cyc();
    start = 1'b0;
    guard = 0;
    while (m_v != 16'hFFFE && guard < 20000) begin
      guard++;
      if (m_st == 2) land();
      else begin
        diff = 16'hFFFE - m_v;
        s = (diff > 16'd15) ? 15 : int'(diff);
        up_tick(s);
      end
    end
    check("t6_reach_fffe", vcnt, 16'hFFFE);
    dy = 16'd400;
    guard = 0;
    while (m_st != 2 && guard < 20) begin up_tick(15); guard++; end
    land();
    check("t6_wrapped_land", qup, 1'b1);
    check("t6_wrapped_hit", hidx, 4'd0);
    dy = 16'd200;
    up_tick(4);
    check("t6_vcnt_wrap", vcnt, 16'h0002);
    check("t6_score_sat", scr, 16'hFFFF);
    up_tick(4);
    check("t6_score_hold", scr, 16'hFFFF);

    // Random traffic against the model, with one reset landing mid-scan.
    do_reset();
    did_mid_reset = 0;
    for (int n = 0; n < 4000; n++) begin
      tick  = ($urandom_range(3) == 0);
      start = ($urandom_range(7) == 0);
      ack   = ($urandom_range(5) == 0);
      spd   = 4'($urandom_range(15));
      ridx  = 4'($urandom_range(15));
      quiet = (m_rem == 0) && !(m_st == 2 && tick);
      we = 1'b0;
      if (quiet && $urandom_range(2) == 0) begin
        we = 1'b1;
        widx = 4'($urandom_range(15));
        wx = dx + 16'($urandom_range(100)) - 16'd50;
        wy = dy + 16'd13 - m_v + 16'($urandom_range(20)) - 16'd10;
        wvalid = ($urandom_range(3) != 0);
      end
      if (quiet && $urandom_range(4) == 0) begin
        dx = 16'($urandom_range(639));
        dy = ($urandom_range(5) == 0) ? 16'($urandom_range(540, 500)) : 16'($urandom_range(450, 100));
      end
      if (!did_mid_reset && n > 2000 && m_rem > 5) begin
        did_mid_reset = 1;
        do_reset();
        check("mid_scan_reset_idle", qi, 1'b1);
      end else begin
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
